// File: rtl/ps2_rx_fifo_if.sv
// rtl/ps2_rx_fifo_if.sv - scan-code byte handshake between the PS/2 receiver FIFO and the decoder
interface ps2_rx_fifo_if;
  logic [7:0] data;
  logic       ready;
  logic       nextdata_n;
  logic       overflow;
  logic       frame_err;

  modport master (
    output data,
    output ready,
    output overflow,
    output frame_err,
    input  nextdata_n
  );

  modport slave (
    input  data,
    input  ready,
    input  overflow,
    input  frame_err,
    output nextdata_n
  );
endinterface

// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - oversampled PS/2 device-to-host receiver with framing/parity check and byte FIFO
module ps2_rx_fifo #(
  parameter int ADDR_W  = 3,
  parameter int TIMEOUT = 100000
) (
  input  logic           clk,
  input  logic           clrn,
  input  logic           ps2_clk,
  input  logic           ps2_data,
  ps2_rx_fifo_if.master  kbd
);
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  logic [2:0]        clk_sync_q, clk_sync_d;
  logic [1:0]        dat_sync_q, dat_sync_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [9:0]        frame_q, frame_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic              overflow_q, overflow_d;
  logic              frame_err_q, frame_err_d;
  logic [7:0]        mem [DEPTH];

  logic fall;
  logic rx_bit;
  logic good;
  logic wr_en;
  logic empty;
  logic full;
  logic pop;

  // clk_sync_q[2] is the oldest sample: a falling edge is old=1, newer=0
  assign fall   = clk_sync_q[2] & ~clk_sync_q[1];
  assign rx_bit = dat_sync_q[1];
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                  (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
  assign pop    = ~empty & ~kbd.nextdata_n;

  always_comb begin
    clk_sync_d  = {clk_sync_q[1:0], ps2_clk};
    dat_sync_d  = {dat_sync_q[0], ps2_data};
    bit_cnt_d   = bit_cnt_q;
    frame_d     = frame_q;
    idle_d      = idle_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q;
    frame_err_d = 1'b0;
    good        = 1'b0;
    wr_en       = 1'b0;

    if (pop) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      overflow_d = 1'b0;
    end

    if (fall) begin
      idle_d = '0;
      if (bit_cnt_q == 4'd10) begin
        // frame_q[0]=start, [8:1]=data, [9]=parity; rx_bit is the stop bit
        bit_cnt_d = 4'd0;
        good      = ~frame_q[0] & rx_bit & (^frame_q[9:1]);
        if (!good) begin
          frame_err_d = 1'b1;
        end else if (full) begin
          overflow_d = 1'b1;
        end else begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
        end
      end else begin
        frame_d   = {rx_bit, frame_q[9:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (idle_q == IDLE_LAST) begin
        bit_cnt_d   = 4'd0;
        idle_d      = '0;
        frame_err_d = 1'b1;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync_q  <= 3'b111;
      dat_sync_q  <= 2'b11;
      bit_cnt_q   <= 4'd0;
      frame_q     <= '0;
      idle_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      dat_sync_q  <= dat_sync_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_q     <= frame_d;
      idle_q      <= idle_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Storage is deliberately left out of reset; only the pointers define validity
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q[ADDR_W-1:0]] <= frame_q[8:1];
    end
  end

  assign kbd.data      = mem[rd_ptr_q[ADDR_W-1:0]];
  assign kbd.ready     = ~empty;
  assign kbd.overflow  = overflow_q;
  assign kbd.frame_err = frame_err_q;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - directed self-checking bench for ps2_rx_fifo
module tb_ps2_rx_fifo;
  localparam int TMO = 200;

  logic clk = 1'b0;
  logic clrn = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   err_seen = 0;

  ps2_rx_fifo_if bus ();

  ps2_rx_fifo #(.ADDR_W(3), .TIMEOUT(TMO)) dut (
    .clk      (clk),
    .clrn     (clrn),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .kbd      (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.frame_err === 1'b1) err_seen++;
  end

  task automatic send_bit(input bit b);
    @(negedge clk);
    ps2_data = b;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (5) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ flip_par);
    send_bit(stop);
    repeat (3) @(negedge clk);
    ps2_data = 1'b1;
  endtask

  task automatic pop_one;
    @(negedge clk);
    bus.nextdata_n = 1'b0;
    @(negedge clk);
    bus.nextdata_n = 1'b1;
  endtask

  task automatic test_reset;
    bus.nextdata_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.ready !== 1'b0) begin
      failures++; $display("FAIL reset_ready got=%b exp=0", bus.ready);
    end
    checks++;
    if (bus.overflow !== 1'b0 || bus.frame_err !== 1'b0) begin
      failures++; $display("FAIL reset_flags got ovf=%b err=%b exp=0/0", bus.overflow, bus.frame_err);
    end
    clrn = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single;
    int lat;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(1'(8'h1C >> i));
    send_bit(1'b0);
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b0;
    lat = 0;
    for (int c = 1; c <= 4 && lat == 0; c++) begin
      @(posedge clk);
      #1;
      if (bus.ready === 1'b1) lat = c;
    end
    checks++;
    if (lat == 0) begin
      failures++; $display("FAIL single_latency got=none exp=ready within 4 cycles");
    end
    repeat (4) @(negedge clk);
    ps2_clk = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.ready !== 1'b1 || bus.data !== 8'h1C) begin
      failures++; $display("FAIL single_data got ready=%b data=%h exp=1/1c", bus.ready, bus.data);
    end
    pop_one();
    checks++;
    if (bus.ready !== 1'b0) begin
      failures++; $display("FAIL single_pop_empty got=%b exp=0", bus.ready);
    end
  endtask

  task automatic test_sequence;
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.ready !== 1'b1 || bus.data !== 8'hF0) begin
      failures++; $display("FAIL seq_first got ready=%b data=%h exp=1/f0", bus.ready, bus.data);
    end
    pop_one();
    checks++;
    if (bus.ready !== 1'b1 || bus.data !== 8'h1C) begin
      failures++; $display("FAIL seq_second got ready=%b data=%h exp=1/1c", bus.ready, bus.data);
    end
    pop_one();
    checks++;
    if (bus.ready !== 1'b0) begin
      failures++; $display("FAIL seq_empty got=%b exp=0", bus.ready);
    end
  endtask

  task automatic test_bad_frames;
    int e0;
    e0 = err_seen;
    send_frame(8'h1C, 1'b1, 1'b1);
    checks++;
    if (err_seen - e0 != 1 || bus.ready !== 1'b0) begin
      failures++; $display("FAIL bad_parity got err_cycles=%0d ready=%b exp=1/0", err_seen - e0, bus.ready);
    end
    e0 = err_seen;
    send_frame(8'h1C, 1'b0, 1'b0);
    checks++;
    if (err_seen - e0 != 1 || bus.ready !== 1'b0) begin
      failures++; $display("FAIL bad_stop got err_cycles=%0d ready=%b exp=1/0", err_seen - e0, bus.ready);
    end
  endtask

  task automatic test_overflow;
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.overflow !== 1'b1 || bus.ready !== 1'b1) begin
      failures++; $display("FAIL ovf_set got ovf=%b ready=%b exp=1/1", bus.overflow, bus.ready);
    end
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (bus.data !== 8'(i) || bus.ready !== 1'b1) begin
        failures++; $display("FAIL ovf_pop%0d got data=%h ready=%b exp=%h/1", i, bus.data, bus.ready, 8'(i));
      end
      pop_one();
      if (i == 1) begin
        checks++;
        if (bus.overflow !== 1'b0) begin
          failures++; $display("FAIL ovf_clear got=%b exp=0", bus.overflow);
        end
      end
    end
    checks++;
    if (bus.ready !== 1'b0) begin
      failures++; $display("FAIL ovf_drained got=%b exp=0", bus.ready);
    end
  endtask

  task automatic test_timeout;
    int e0;
    e0 = err_seen;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    repeat (TMO + 10) @(negedge clk);
    checks++;
    if (err_seen - e0 != 1) begin
      failures++; $display("FAIL timeout_err got=%0d exp=1", err_seen - e0);
    end
    e0 = err_seen;
    send_frame(8'h5A, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.ready !== 1'b1 || bus.data !== 8'h5A || err_seen != e0) begin
      failures++; $display("FAIL timeout_recover got ready=%b data=%h err=%0d exp=1/5a/0", bus.ready, bus.data, err_seen - e0);
    end
    pop_one();
  endtask

  task automatic test_reset_midframe;
    send_frame(8'h21, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1);
    send_frame(8'h23, 1'b0, 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    @(negedge clk);
    clrn = 1'b0;
    #1;
    checks++;
    if (bus.ready !== 1'b0) begin
      failures++; $display("FAIL midreset_ready got=%b exp=0", bus.ready);
    end
    repeat (3) @(negedge clk);
    clrn = 1'b1;
    repeat (3) @(negedge clk);
    send_frame(8'h12, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.ready !== 1'b1 || bus.data !== 8'h12) begin
      failures++; $display("FAIL midreset_byte got ready=%b data=%h exp=1/12", bus.ready, bus.data);
    end
    pop_one();
    checks++;
    if (bus.ready !== 1'b0) begin
      failures++; $display("FAIL midreset_only got=%b exp=0", bus.ready);
    end
  endtask

  initial begin
    bus.nextdata_n = 1'b1;
    test_reset();
    test_single();
    test_sequence();
    test_bad_frames();
    test_overflow();
    test_timeout();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
